// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage iterative multiply/divide unit owning HI/LO
module ex_muldiv_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Flush,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic        DivByZero
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_dvsr;
    logic [5:0]  div_cnt;
    logic        neg_quo;
    logic        neg_rem;

    logic [63:0] product;
    logic        div_signed;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [32:0] shifted;
    logic        trial_ge;
    logic [31:0] trial_diff;

    // Operands are sign- or zero-extended to 64 bits at accept, so one
    // truncated 64-bit product serves both MULT and MULTU.
    always_comb begin
        product    = mul_a * mul_b;
        div_signed = (Op == OP_DIV);
        rs_neg     = div_signed && RsData[31];
        rt_neg     = div_signed && RtData[31];
        abs_rs     = rs_neg ? (32'd0 - RsData) : RsData;
        abs_rt     = rt_neg ? (32'd0 - RtData) : RtData;
        shifted    = {div_rem, div_quo[31]};
        trial_ge   = (shifted >= {1'b0, div_dvsr});
        // The true difference is below the divisor, so the low 32 bits suffice.
        trial_diff = shifted[31:0] - div_dvsr;
    end

    assign Stall = Busy;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= S_IDLE;
            HI        <= 32'd0;
            LO        <= 32'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            mul_a     <= 64'd0;
            mul_b     <= 64'd0;
            div_rem   <= 32'd0;
            div_quo   <= 32'd0;
            div_dvsr  <= 32'd0;
            div_cnt   <= 6'd0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            if (Flush) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Start) begin
                            case (Op)
                                OP_MTHI: HI <= RsData;
                                OP_MTLO: LO <= RsData;
                                OP_MULT, OP_MULTU: begin
                                    if (Op == OP_MULT) begin
                                        mul_a <= {{32{RsData[31]}}, RsData};
                                        mul_b <= {{32{RtData[31]}}, RtData};
                                    end else begin
                                        mul_a <= {32'd0, RsData};
                                        mul_b <= {32'd0, RtData};
                                    end
                                    state <= S_MUL;
                                    Busy  <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (RtData == 32'd0) begin
                                        Done      <= 1'b1;
                                        DivByZero <= 1'b1;
                                    end else begin
                                        div_rem  <= 32'd0;
                                        div_quo  <= abs_rs;
                                        div_dvsr <= abs_rt;
                                        div_cnt  <= 6'd32;
                                        neg_quo  <= rs_neg ^ rt_neg;
                                        neg_rem  <= rs_neg;
                                        state    <= S_DIV;
                                        Busy     <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        HI    <= product[63:32];
                        LO    <= product[31:0];
                        Done  <= 1'b1;
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                    S_DIV: begin
                        if (trial_ge) begin
                            div_rem <= trial_diff;
                            div_quo <= {div_quo[30:0], 1'b1};
                        end else begin
                            div_rem <= shifted[31:0];
                            div_quo <= {div_quo[30:0], 1'b0};
                        end
                        div_cnt <= div_cnt - 6'd1;
                        if (div_cnt == 6'd1) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        LO    <= neg_quo ? (32'd0 - div_quo) : div_quo;
                        HI    <= neg_rem ? (32'd0 - div_rem) : div_rem;
                        Done  <= 1'b1;
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        CLK;
    logic        Reset;
    logic        Flush;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        DivByZero;

    int tests;
    int fails;

    ex_muldiv_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Flush     (Flush),
        .Start     (Start),
        .Op        (Op),
        .RsData    (RsData),
        .RtData    (RtData),
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy),
        .Stall     (Stall),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        Start  = 1'b1;
        Op     = op;
        RsData = rs;
        RtData = rt;
        tick();
        Start  = 1'b0;
        Op     = 3'b000;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Flush = 1'b0; Start = 1'b0; Op = 3'b000; RsData = 0; RtData = 0;
        tick(); tick();
        Reset = 1'b0;
        tests++; if (HI !== 32'd0) begin fails++; $display("FAIL reset_hi got %h exp 0", HI); end
        tests++; if (LO !== 32'd0) begin fails++; $display("FAIL reset_lo got %h exp 0", LO); end
        tests++; if (Busy !== 1'b0 || Stall !== 1'b0) begin fails++; $display("FAIL reset_busy got %b/%b exp 0/0", Busy, Stall); end
        tests++; if (Done !== 1'b0 || DivByZero !== 1'b0) begin fails++; $display("FAIL reset_done got %b/%b exp 0/0", Done, DivByZero); end
    endtask

    task automatic test_mult();
        issue(3'b001, 32'hFFFFFFFE, 32'h00000003);
        tests++; if (Busy !== 1'b1 || Stall !== 1'b1) begin fails++; $display("FAIL mult_busy got %b/%b exp 1/1", Busy, Stall); end
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL mult_early_done got %b exp 0", Done); end
        tick();
        tests++; if (Busy !== 1'b0 || Stall !== 1'b0) begin fails++; $display("FAIL mult_busy_drop got %b/%b exp 0/0", Busy, Stall); end
        tests++; if (Done !== 1'b1) begin fails++; $display("FAIL mult_done got %b exp 1", Done); end
        tests++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_result got %h_%h exp ffffffff_fffffffa", HI, LO); end
        tick();
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got %b exp 0", Done); end
        issue(3'b010, 32'hFFFFFFFE, 32'h00000003);
        tick();
        tests++; if (Done !== 1'b1 || HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
            fails++; $display("FAIL multu_result got done=%b %h_%h exp 1 00000002_fffffffa", Done, HI, LO);
        end
        tick();
    endtask

    task automatic run_div(input string name, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, rs, rt);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        tests++; if (n != 33) begin fails++; $display("FAIL %s_busy_cycles got %0d exp 33", name, n); end
        tests++; if (Done !== 1'b1 || DivByZero !== 1'b0) begin fails++; $display("FAIL %s_done got %b/%b exp 1/0", name, Done, DivByZero); end
        tests++; if (HI !== exp_hi || LO !== exp_lo) begin fails++; $display("FAIL %s_result got %h_%h exp %h_%h", name, HI, LO, exp_hi, exp_lo); end
        tick();
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse got %b exp 0", name, Done); end
    endtask

    task automatic test_div();
        run_div("div_neg7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("divu_100_7", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("div_min_neg1", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_div("div_7_neg2", 3'b011, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    endtask

    task automatic test_div_by_zero();
        issue(3'b100, 32'd5, 32'd0);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL dbz_busy got %b exp 0", Busy); end
        tests++; if (Done !== 1'b1 || DivByZero !== 1'b1) begin fails++; $display("FAIL dbz_pulse got %b/%b exp 1/1", Done, DivByZero); end
        tests++; if (HI !== 32'd1 || LO !== 32'hFFFFFFFD) begin fails++; $display("FAIL dbz_hilo got %h_%h exp 00000001_fffffffd", HI, LO); end
        tick();
        tests++; if (Done !== 1'b0 || DivByZero !== 1'b0) begin fails++; $display("FAIL dbz_pulse_end got %b/%b exp 0/0", Done, DivByZero); end
    endtask

    task automatic test_mthi_mtlo();
        Start = 1'b1; Op = 3'b101; RsData = 32'h12345678;
        tick();
        tests++; if (HI !== 32'h12345678 || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++; $display("FAIL mthi got hi=%h busy=%b done=%b exp 12345678 0 0", HI, Busy, Done);
        end
        Op = 3'b110; RsData = 32'h9ABCDEF0;
        tick();
        Start = 1'b0; Op = 3'b000;
        tests++; if (LO !== 32'h9ABCDEF0 || HI !== 32'h12345678 || Busy !== 1'b0 || Done !== 1'b0) begin
            fails++; $display("FAIL mtlo got %h_%h busy=%b done=%b exp 12345678_9abcdef0 0 0", HI, LO, Busy, Done);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        issue(3'b011, 32'hFFFFFF9C, 32'd7);
        Start = 1'b1; Op = 3'b001; RsData = 32'd3; RtData = 32'd4;
        repeat (5) tick();
        Start = 1'b0; Op = 3'b000;
        n = 5;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        tests++; if (n != 33 || Done !== 1'b1) begin fails++; $display("FAIL busy_ignore_timing got cycles=%0d done=%b exp 33 1", n, Done); end
        tests++; if (HI !== 32'hFFFFFFFE || LO !== 32'hFFFFFFF2) begin fails++; $display("FAIL busy_ignore_result got %h_%h exp fffffffe_fffffff2", HI, LO); end
        tick();
        tests++; if (Busy !== 1'b0 || Done !== 1'b0) begin fails++; $display("FAIL busy_ignore_after got %b/%b exp 0/0", Busy, Done); end
    endtask

    task automatic test_flush();
        issue(3'b100, 32'd1000, 32'd3);
        repeat (9) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        tests++; if (Busy !== 1'b0 || Done !== 1'b0) begin fails++; $display("FAIL flush_idle got %b/%b exp 0/0", Busy, Done); end
        tests++; if (HI !== 32'hFFFFFFFE || LO !== 32'hFFFFFFF2) begin fails++; $display("FAIL flush_hilo got %h_%h exp fffffffe_fffffff2", HI, LO); end
        repeat (40) begin
            tick();
            tests++; if (Done !== 1'b0 || Busy !== 1'b0) begin fails++; $display("FAIL flush_no_done got %b/%b exp 0/0", Done, Busy); end
        end
        Flush = 1'b1;
        issue(3'b001, 32'd3, 32'd4);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL flush_start_mult got busy=%b exp 0", Busy); end
        issue(3'b101, 32'hDEADBEEF, 32'd0);
        Flush = 1'b0;
        tests++; if (HI !== 32'hFFFFFFFE || Done !== 1'b0) begin fails++; $display("FAIL flush_start_mthi got hi=%h done=%b exp fffffffe 0", HI, Done); end
    endtask

    task automatic test_reset_mid_div();
        issue(3'b011, 32'd12345, 32'd17);
        repeat (19) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests++; if (HI !== 32'd0 || LO !== 32'd0) begin fails++; $display("FAIL rst_div_hilo got %h_%h exp 0_0", HI, LO); end
        tests++; if (Busy !== 1'b0 || Done !== 1'b0 || DivByZero !== 1'b0) begin
            fails++; $display("FAIL rst_div_flags got %b%b%b exp 000", Busy, Done, DivByZero);
        end
        repeat (20) tick();
        tests++; if (Done !== 1'b0 || Busy !== 1'b0) begin fails++; $display("FAIL rst_div_after got %b/%b exp 0/0", Done, Busy); end
        issue(3'b101, 32'h00000055, 32'd0);
        Reset = 1'b1; Flush = 1'b1;
        issue(3'b110, 32'h00000077, 32'd0);
        Reset = 1'b0; Flush = 1'b0;
        tests++; if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
            fails++; $display("FAIL rst_flush got %h_%h busy=%b exp 0_0 0", HI, LO, Busy);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'b001, 32'd9, 32'hFFFFFFFF);
        tick();
        tests++; if (Done !== 1'b1 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF7) begin
            fails++; $display("FAIL b2b_first got done=%b %h_%h exp 1 ffffffff_fffffff7", Done, HI, LO);
        end
        issue(3'b010, 32'd5, 32'd6);
        tests++; if (Busy !== 1'b1 || Done !== 1'b0) begin fails++; $display("FAIL b2b_accept got %b/%b exp 1/0", Busy, Done); end
        tick();
        tests++; if (Done !== 1'b1 || HI !== 32'd0 || LO !== 32'd30) begin
            fails++; $display("FAIL b2b_second got done=%b %h_%h exp 1 00000000_0000001e", Done, HI, LO);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_mthi_mtlo();
        test_start_while_busy();
        test_flush();
        test_reset_mid_div();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
